// File: rtl/dmem_axil_ctrl.sv
// AXI4-Lite slave for the single-port data memory: one holding entry per AW/W/AR channel, one access in flight.
// Latency: last AW/W handshake -> mem_en +1 cycle, bvalid +2; AR handshake -> mem_en +1, rvalid +3.
// Backpressure: B/R responses stall the FSM indefinitely; a channel deasserts ready only while its entry is full.
module dmem_axil_ctrl #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              awvalid,
   output logic              awready,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [2:0]        awprot,
   input  logic              wvalid,
   output logic              wready,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   output logic              bvalid,
   input  logic              bready,
   output logic [1:0]        bresp,
   input  logic              arvalid,
   output logic              arready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [2:0]        arprot,
   output logic              rvalid,
   input  logic              rready,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rresp,
   output logic              mem_en,
   output logic [STRB_W-1:0] mem_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RLAT, RRESP} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
   } req_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic       GNT_RD      = 1'b0;
   localparam logic       GNT_WR      = 1'b1;

   state_t            state, state_nxt;
   logic              aw_full, w_full, ar_full;
   logic [ADDR_W-1:0] awaddr_q, araddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q;
   req_t              cur_q;
   logic              last_grant;
   logic              grant_wr, grant_rd;
   logic              cur_misaligned;
   logic [1:0]        bresp_q, rresp_q;
   logic [DATA_W-1:0] rdata_q;
   logic              unused_prot;

   assign unused_prot    = ^{awprot, arprot};
   assign cur_misaligned = (cur_q.addr[1:0] != 2'b00);

   // Readies are forced low while reset is held so every output reads 0 during reset.
   assign awready = !aw_full && !reset;
   assign wready  = !w_full  && !reset;
   assign arready = !ar_full && !reset;
   assign bresp   = bresp_q;
   assign rresp   = rresp_q;
   assign rdata   = rdata_q;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_wr  = 1'b0;
      grant_rd  = 1'b0;
      mem_en    = 1'b0;
      mem_we    = '0;
      mem_adr   = '0;
      mem_wdata = '0;
      bvalid    = 1'b0;
      rvalid    = 1'b0;
      case (state)
         IDLE: begin
            // Write wins when it is the only one ready, or on contention when the read went last.
            if (aw_full && w_full && (!ar_full || last_grant == GNT_RD)) begin
               grant_wr  = 1'b1;
               state_nxt = WR;
            end else if (ar_full) begin
               grant_rd  = 1'b1;
               state_nxt = RD;
            end
         end
         WR: begin
            mem_adr   = cur_q.addr;
            mem_wdata = cur_q.data;
            if (!cur_misaligned && cur_q.strb != '0) begin
               mem_en = 1'b1;
               mem_we = cur_q.strb;
            end
            state_nxt = WRESP;
         end
         WRESP: begin
            bvalid = 1'b1;
            if (bready) state_nxt = IDLE;
         end
         RD: begin
            mem_adr   = cur_q.addr;
            mem_en    = !cur_misaligned;
            state_nxt = RLAT;
         end
         RLAT: state_nxt = RRESP;
         RRESP: begin
            rvalid = 1'b1;
            if (rready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         aw_full    <= 1'b0;
         w_full     <= 1'b0;
         ar_full    <= 1'b0;
         awaddr_q   <= '0;
         araddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         cur_q      <= '0;
         last_grant <= GNT_RD;
         bresp_q    <= RESP_OKAY;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
      end else begin
         if (awvalid && !aw_full) begin
            aw_full  <= 1'b1;
            awaddr_q <= awaddr;
         end else if (grant_wr) begin
            aw_full <= 1'b0;
         end
         if (wvalid && !w_full) begin
            w_full  <= 1'b1;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end else if (grant_wr) begin
            w_full <= 1'b0;
         end
         if (arvalid && !ar_full) begin
            ar_full  <= 1'b1;
            araddr_q <= araddr;
         end else if (grant_rd) begin
            ar_full <= 1'b0;
         end

         // The granted request moves to cur_q so its holding entry can refill during execution.
         if (grant_wr) begin
            cur_q.addr <= awaddr_q;
            cur_q.data <= wdata_q;
            cur_q.strb <= wstrb_q;
            if (ar_full) last_grant <= GNT_WR;
         end
         if (grant_rd) begin
            cur_q.addr <= araddr_q;
            cur_q.data <= '0;
            cur_q.strb <= '0;
            if (aw_full && w_full) last_grant <= GNT_RD;
         end

         if (state == WR) bresp_q <= cur_misaligned ? RESP_SLVERR : RESP_OKAY;
         if (state == RD) rresp_q <= cur_misaligned ? RESP_SLVERR : RESP_OKAY;
         if (state == RLAT) rdata_q <= (rresp_q == RESP_SLVERR) ? '0 : mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_axil_ctrl.sv
// Directed and random AXI4-Lite traffic against dmem_axil_ctrl with a behavioural memory macro
// and a word-array reference of the memory contents updated in grant order.
module tb_dmem_axil_ctrl;

   typedef struct {
      int         cyc;
      logic [3:0] we;
   } en_rec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [11:0] awaddr, araddr, mem_adr;
   logic [2:0]  awprot, arprot;
   logic [31:0] wdata, rdata, mem_wdata, mem_rdata;
   logic [3:0]  wstrb, mem_we;
   logic [1:0]  bresp, rresp;
   logic        mem_en;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          en_cnt = 0;
   int          last_en_cyc = -1;
   logic [3:0]  last_we;
   logic [11:0] last_adr;
   logic [31:0] last_wd;
   en_rec_t     en_log[$];
   logic [31:0] mem_arr [1024];
   logic [31:0] ref_mem [1024];

   localparam logic [1:0] OK  = 2'b00;
   localparam logic [1:0] SLV = 2'b10;

   dmem_axil_ctrl dut (
      .clk(clk), .reset(reset),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-port memory macro: read data appears the cycle after mem_en.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 1024; i++) mem_arr[i] <= '0;
         mem_rdata <= '0;
      end else if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem_arr[mem_adr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= mem_arr[mem_adr[11:2]];
      end
   end

   always @(negedge clk) begin
      if (mem_en === 1'b1) begin
         en_cnt++;
         last_en_cyc = cyc;
         last_we     = mem_we;
         last_adr    = mem_adr;
         last_wd     = mem_wdata;
         en_log.push_back('{cyc: cyc, we: mem_we});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) if (s[b]) res[8*b +: 8] = d[8*b +: 8];
      return res;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, output int hs);
      bit aw_done, w_done, ah, wh;
      int n;
      aw_done = 0; w_done = 0; n = 0;
      awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
      while (!(aw_done && w_done) && n < 50) begin
         @(negedge clk);
         ah = awvalid && awready;
         wh = wvalid && wready;
         @(posedge clk); #1;
         n++;
         if (ah) begin awvalid = 0; aw_done = 1; end
         if (wh) begin wvalid = 0; w_done = 1; end
      end
      awvalid = 0; wvalid = 0; hs = cyc;
      chk("wr_handshake", {aw_done, w_done}, 2'b11);
   endtask

   task automatic do_read(input logic [11:0] a, output int hs);
      bit done;
      int n;
      done = 0; n = 0;
      arvalid = 1; araddr = a;
      while (!done && n < 50) begin
         @(negedge clk);
         done = arready;
         @(posedge clk); #1;
         n++;
      end
      arvalid = 0; hs = cyc;
      chk("rd_handshake", done, 1);
   endtask

   task automatic wait_b(output int c, output logic [1:0] r);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (bvalid !== 1'b1 && n < 50);
      chk("b_timeout", bvalid, 1);
      c = cyc; r = bresp;
   endtask

   task automatic wait_r(output int c, output logic [1:0] r, output logic [31:0] d);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (rvalid !== 1'b1 && n < 50);
      chk("r_timeout", rvalid, 1);
      c = cyc; r = rresp; d = rdata;
   endtask

   task automatic finish_write(input int hs, input logic [11:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [1:0] er, input bit ee);
      int e0, c;
      logic [1:0] r;
      e0 = en_cnt;
      wait_b(c, r);
      chk("b_latency", c, hs + 2);
      chk("bresp", r, er);
      chk("wr_en_pulses", en_cnt - e0, ee);
      if (ee) begin
         chk("wr_en_cycle", last_en_cyc, hs + 1);
         chk("wr_we_adr", {last_we, last_adr}, {s, a});
         chk("wr_wdata", last_wd, d);
      end
      @(posedge clk); #1;
   endtask

   task automatic finish_read(input int hs, input logic [11:0] a, input logic [1:0] er,
                              input logic [31:0] ed, input bit ee);
      int e0, c;
      logic [1:0] r;
      logic [31:0] d;
      e0 = en_cnt;
      wait_r(c, r, d);
      chk("r_latency", c, hs + 3);
      chk("rresp", r, er);
      chk("rdata", d, ed);
      chk("rd_en_pulses", en_cnt - e0, ee);
      if (ee) begin
         chk("rd_en_cycle", last_en_cyc, hs + 1);
         chk("rd_we_adr", {last_we, last_adr}, {4'h0, a});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int hs, c, e0, ahs, e_idx;
      logic [1:0] r;
      logic [31:0] d, ed;
      bit seen_rv;

      reset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("reset_ctrl", {awready, wready, arready, bvalid, rvalid, mem_en, mem_we, bresp, rresp}, 0);
      chk("reset_data", {rdata, mem_wdata, mem_adr}, 0);
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("post_reset_ready", {awready, wready, arready}, 3'b111);
      @(posedge clk); #1;

      // Contention right after reset: write first, then the read sees that write.
      e_idx = en_log.size();
      awvalid = 1; awaddr = 12'h020; wvalid = 1; wdata = 32'hA5A5_0F0F; wstrb = 4'hF;
      arvalid = 1; araddr = 12'h020;
      @(posedge clk); #1;
      hs = cyc;
      awvalid = 0; wvalid = 0; arvalid = 0;
      ref_mem[8] = merge(ref_mem[8], 32'hA5A5_0F0F, 4'hF);
      wait_b(c, r);
      chk("c1_b_latency", c, hs + 2);
      chk("c1_bresp", r, OK);
      @(posedge clk); #1;
      wait_r(c, r, d);
      chk("c1_r_latency", c, hs + 6);
      chk("c1_rdata", d, ref_mem[8]);
      @(posedge clk); #1;
      chk("c1_en_count", en_log.size() - e_idx, 2);
      if (en_log.size() - e_idx == 2) begin
         chk("c1_first_is_write", en_log[e_idx].we, 4'hF);
         chk("c1_second_is_read", en_log[e_idx + 1].we, 4'h0);
      end

      // Next contention goes to the read, which sees the old contents.
      e_idx = en_log.size();
      awvalid = 1; awaddr = 12'h024; wvalid = 1; wdata = 32'h5A5A_F0F0; wstrb = 4'hF;
      arvalid = 1; araddr = 12'h024;
      @(posedge clk); #1;
      hs = cyc;
      awvalid = 0; wvalid = 0; arvalid = 0;
      ed = ref_mem[9];
      ref_mem[9] = merge(ref_mem[9], 32'h5A5A_F0F0, 4'hF);
      wait_r(c, r, d);
      chk("c2_r_latency", c, hs + 3);
      chk("c2_rdata_old", d, ed);
      @(posedge clk); #1;
      wait_b(c, r);
      chk("c2_b_latency", c, hs + 6);
      @(posedge clk); #1;
      chk("c2_en_count", en_log.size() - e_idx, 2);
      if (en_log.size() - e_idx == 2) chk("c2_first_is_read", en_log[e_idx].we, 4'h0);

      // W one cycle ahead of AW.
      wvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
      @(posedge clk); #1;
      wvalid = 0; awvalid = 1; awaddr = 12'h010;
      @(posedge clk); #1;
      awvalid = 0; hs = cyc;
      ref_mem[4] = merge(ref_mem[4], 32'hDEAD_BEEF, 4'hF);
      @(negedge clk);
      chk("w_first_no_early_en", mem_en, 0);
      finish_write(hs, 12'h010, 32'hDEAD_BEEF, 4'hF, OK, 1);

      do_read(12'h010, hs);
      finish_read(hs, 12'h010, OK, ref_mem[4], 1);

      do_write(12'h010, 32'h0000_AB00, 4'h2, hs);
      ref_mem[4] = merge(ref_mem[4], 32'h0000_AB00, 4'h2);
      finish_write(hs, 12'h010, 32'h0000_AB00, 4'h2, OK, 1);
      do_read(12'h010, hs);
      finish_read(hs, 12'h010, OK, ref_mem[4], 1);

      // Misaligned accesses: no memory pulse, SLVERR, read data forced to 0.
      do_read(12'h013, hs);
      finish_read(hs, 12'h013, SLV, 32'h0, 0);
      do_write(12'h006, 32'h1234_5678, 4'hF, hs);
      finish_write(hs, 12'h006, 32'h1234_5678, 4'hF, SLV, 0);

      for (int it = 0; it < 40; it++) begin
         logic [11:0] a;
         logic [31:0] dd;
         logic [3:0]  s;
         bit mis;
         a   = 12'($urandom_range(0, 63) * 4);
         mis = ($urandom_range(0, 7) == 0);
         if (mis) a[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 1) == 1) begin
            dd = $urandom;
            s  = 4'($urandom_range(0, 15));
            do_write(a, dd, s, hs);
            if (!mis) ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], dd, s);
            finish_write(hs, a, dd, s, mis ? SLV : OK, !mis && s != 4'h0);
         end else begin
            ed = mis ? 32'h0 : ref_mem[a[11:2]];
            do_read(a, hs);
            finish_read(hs, a, mis ? SLV : OK, ed, !mis);
         end
      end

      // B backpressure for 5 cycles with an AR accepted meanwhile, then reset during RLAT.
      bready = 0;
      do_write(12'h030, 32'hCAFE_F00D, 4'hF, hs);
      wait_b(c, r);
      chk("bp_b_latency", c, hs + 2);
      e0 = en_cnt;
      @(posedge clk); #1;
      do_read(12'h030, ahs);
      chk("bp_ar_accepted", ahs, hs + 4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_b_held", {bvalid, bresp}, 3'b100);
         @(posedge clk); #1;
      end
      chk("bp_no_en_while_stalled", en_cnt - e0, 0);
      bready = 1;
      @(negedge clk);
      chk("bp_b_still_valid", bvalid, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_idle_after_b", {bvalid, mem_en}, 2'b00);
      @(negedge clk);
      chk("bp_read_starts", {mem_en, mem_we, mem_adr}, {1'b1, 4'h0, 12'h030});
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      chk("rlat_reset_ctrl", {awready, wready, arready, bvalid, rvalid, mem_en, mem_we, bresp, rresp}, 0);
      chk("rlat_reset_data", {rdata, mem_wdata, mem_adr}, 0);
      @(posedge clk); #1;
      reset = 0;
      seen_rv = 0;
      repeat (6) begin
         @(negedge clk);
         if (rvalid !== 1'b0) seen_rv = 1;
      end
      chk("rlat_reset_drops_read", seen_rv, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
